pattern_gen: RTL

//  Serial pattern transmitter; the sending end of the single-bit line that patternMoore watches.

---
 rtl/pattern_gen_pkg.sv | 24 ++
 rtl/pattern_gen_if.sv | 32 +++
 rtl/pattern_gen_shift_reg.sv | 48 ++++
 rtl/pattern_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pattern_gen_pkg.sv
// Shared types for the serial pattern transmitter and its detector peer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pattern_gen_pkg;

  // Transmitter job states.
  typedef enum logic [1:0] {
    G_IDLE,
    G_SHIFT,
    G_GAP,
    G_DONE
  } gen_state_t;

  // Detector state type used by the receiving end of the line.
  typedef enum logic [1:0] {
    D_IDLE,
    D_SEEN0,
    D_SEEN01
  } det_state_t;

  // Line level when no pattern bit is on the wire; 1 cannot fake a 0->1 edge.
  localparam logic IDLE_LVL_DEFAULT = 1'b1;

endpackage

// File: rtl/pattern_gen_if.sv
// Job request / serial line bundle between a pattern source and pattern_gen.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while ready=1; nothing is queued.
// Ports (slave view): start, abort, pattern, len, reps, gap in; a, a_valid, ready, done out.
interface pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             a;
  logic             a_valid;
  logic             ready;
  logic             done;

  modport master (
    output start, abort, pattern, len, reps, gap,
    input  a, a_valid, ready, done
  );

  modport slave (
    input  start, abort, pattern, len, reps, gap,
    output a, a_valid, ready, done
  );
endinterface

// File: rtl/pattern_gen_shift_reg.sv
// Loadable MSB-first shifter with a bit-index down-counter.
// Latency: loaded field's top bit is on bit_out the cycle after load.
// Backpressure: none; load wins over shift.
// Ports: clk, reset, load, shift, pattern, len in; bit_out, last_bit out.
module pattern_gen_shift_reg #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_LVL = 1'b1,
  parameter int   LEN_W    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             bit_out,
  output logic             last_bit
);
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] aligned;
  logic [LEN_W-1:0] idx;

  // Field bits [len-1:0] move to the top of the register; everything below
  // is idle level, so once the field has shifted out the line rests at idle
  // without extra muxing. len=0 yields an all-idle register (used to clear).
  always_comb begin
    mask    = ~({WIDTH{1'b1}} >> len);
    aligned = ((pattern << (LEN_W'(WIDTH) - len)) & mask)
            | (~mask & {WIDTH{IDLE_LVL}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= {WIDTH{IDLE_LVL}};
      idx  <= '0;
    end else if (load) begin
      sreg <= aligned;
      idx  <= len - LEN_W'(1);
    end else if (shift) begin
      sreg <= {sreg[WIDTH-2:0], IDLE_LVL};
      if (idx != '0) idx <= idx - LEN_W'(1);
    end
  end

  assign bit_out  = sreg[WIDTH-1];
  assign last_bit = (idx == '0);
endmodule

// File: rtl/pattern_gen.sv
// Serial pattern transmitter: sends len bits MSB-of-field first, reps+1 times, gap idles between.
// Latency: first bit one cycle after accept; done at N+1+(reps+1)*len+reps*gap (N+1 for len=0).
// Backpressure: start accepted only while ready=1 (idle or done cycle); abort always wins.
// Ports: clk, reset (sync, active-high); bus = pattern_gen_if slave.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 4,
  parameter int   GAP_W    = 4,
  parameter logic IDLE_LVL = IDLE_LVL_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  pattern_gen_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  gen_state_t       state, next;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             a_valid_q, ready_q, done_q;

  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] sr_pat;
  logic [LEN_W-1:0] sr_len;
  logic             load, shift, cap, rep_step;
  logic             bit_out, last_bit;

  always_comb len_c = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;

  always_comb begin
    next     = state;
    load     = 1'b0;
    shift    = 1'b0;
    cap      = 1'b0;
    rep_step = 1'b0;
    sr_pat   = pat_q;
    sr_len   = len_q;
    if (bus.abort) begin
      // Loading an empty field parks the line at idle on the next cycle.
      next   = G_IDLE;
      load   = 1'b1;
      sr_len = '0;
    end else begin
      case (state)
        G_IDLE, G_DONE: begin
          next = G_IDLE;
          if (bus.start) begin
            cap    = 1'b1;
            sr_pat = bus.pattern;
            sr_len = len_c;
            if (len_c != '0) begin
              next = G_SHIFT;
              load = 1'b1;
            end else begin
              next = G_DONE;
            end
          end
        end
        G_SHIFT: begin
          if (!last_bit) begin
            shift = 1'b1;
          end else if (rep_cnt != '0) begin
            rep_step = 1'b1;
            if (gap_q != '0) begin
              next  = G_GAP;
              shift = 1'b1;
            end else begin
              load = 1'b1;  // next repetition starts with no idle cycle
            end
          end else begin
            next  = G_DONE;
            shift = 1'b1;
          end
        end
        G_GAP: begin
          if (gap_cnt == '0) begin
            next = G_SHIFT;
            load = 1'b1;
          end
        end
        default: next = G_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= G_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      rep_cnt   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      a_valid_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state     <= next;
      // Flag outputs are decoded from the next state so they are plain flops.
      a_valid_q <= (next == G_SHIFT);
      ready_q   <= (next == G_IDLE) || (next == G_DONE);
      done_q    <= (next == G_DONE);
      if (bus.abort) begin
        rep_cnt <= '0;
        gap_cnt <= '0;
      end else if (cap) begin
        pat_q   <= bus.pattern;
        len_q   <= len_c;
        rep_cnt <= bus.reps;
        gap_q   <= bus.gap;
      end else if (rep_step) begin
        rep_cnt <= rep_cnt - CNT_W'(1);
        gap_cnt <= gap_q - GAP_W'(1);
      end else if (state == G_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  pattern_gen_shift_reg #(
    .WIDTH   (WIDTH),
    .IDLE_LVL(IDLE_LVL),
    .LEN_W   (LEN_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .pattern (sr_pat),
    .len     (sr_len),
    .bit_out (bit_out),
    .last_bit(last_bit)
  );

  assign bus.a       = bit_out;
  assign bus.a_valid = a_valid_q;
  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
endmodule
